pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the 5-stage RV32I pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
It detects load-use hazards, taken-branch redirects and multi-cycle data-memory accesses, and drives per-register enable/flush strobes plus PC_EN.
A small FSM tracks memory waits with a timeout. A saturating counter reports stall cycles for performance monitoring.

Parameters:
MEM_TIMEOUT, 15, max consecutive MEM_WAIT cycles without MEM_ACK before entering ERROR (legal range 1..255).
STALL_CNT_W, 16, width of the stall-cycle counter.

Ports:
CLK  input  1  core clock, rising edge.
RST_N  input  1  asynchronous active-low reset.
ID_RS1  input  5  rs1 of instruction in ID.
ID_RS2  input  5  rs2 of instruction in ID.
ID_RS1_USED  input  1  ID instruction reads rs1.
ID_RS2_USED  input  1  ID instruction reads rs2.
EX_RD  input  5  rd of instruction in EX (INSTRUCTION[11:7]).
EX_REG_WRITE_EN  input  1  EX instruction writes rd.
EX_WB_SEL  input  2  EX writeback select; 2'b01 = load data.
EX_BRANCH_TAKEN  input  1  branch/jump in EX resolved taken.
MEM_REQ  input  1  EX/MEM stage holds a load/store (READ_WRITE != 0).
MEM_ACK  input  1  data memory completes access this cycle.
PC_EN  output  1  PC update enable.
IF_ID_EN  output  1  IF/ID register enable.
IF_ID_FLUSH  output  1  IF/ID loads bubble (NOP, REG_WRITE_EN=0).
ID_EX_EN  output  1  ID/EX register enable.
ID_EX_FLUSH  output  1  ID/EX loads bubble.
EX_MEM_EN  output  1  EX/MEM register enable.
MEM_WB_FLUSH  output  1  MEM/WB loads bubble.
STATE  output  2  current FSM state.
MEM_TIMEOUT_ERR  output  1  sticky timeout flag.
STALL_CNT  output  STALL_CNT_W  saturating count of cycles with PC_EN=0.

Behaviour:
- Reset (RST_N=0, async):
  - STATE=RUN, timeout counter=0, STALL_CNT=0, MEM_TIMEOUT_ERR=0.
  - All *_EN forced 0, all *_FLUSH forced 0 while RST_N low.
- States: RUN=2'b00, LOAD_STALL=2'b01, MEM_WAIT=2'b10, ERROR=2'b11.
- Strobes are combinational from state and inputs; state and counters are registered.
- mem_hold = MEM_REQ & ~MEM_ACK.
- load_use = EX_WB_SEL==2'b01 & EX_REG_WRITE_EN & EX_RD!=0 & ((ID_RS1_USED & ID_RS1==EX_RD) | (ID_RS2_USED & ID_RS2==EX_RD)).
- Default (no event): all EN=1, all FLUSH=0.
- Priority in RUN/LOAD_STALL is mem_hold > branch > load_use.
  - mem_hold:
    - PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN = 0.
    - MEM_WB_FLUSH=1.
    - Next state MEM_WAIT, timeout counter cleared to 1.
  - EX_BRANCH_TAKEN:
    - IF_ID_FLUSH=1, ID_EX_FLUSH=1, all EN=1.
    - Next state RUN. Branch overrides a simultaneous load_use, because the dependent instruction is squashed.
  - load_use (RUN only):
    - PC_EN=0, IF_ID_EN=0, ID_EX_FLUSH=1, EX_MEM_EN=1.
    - Next state LOAD_STALL.
    - Exactly one bubble per hazard.
- LOAD_STALL:
  - load_use detection is masked.
  - Default strobes unless mem_hold/branch.
  - Returns to RUN next cycle.
- MEM_WAIT:
  - Strobes as for mem_hold.
  - On MEM_ACK: default strobes (pipeline advances that cycle), EX_BRANCH_TAKEN honoured with the same flush strobes; next state RUN.
  - Without MEM_ACK: the counter increments. When the counter equals MEM_TIMEOUT and no ACK arrives, the next state is ERROR.
  - MEM_ACK in the same cycle as the timeout compare wins (no error).
- ERROR:
  - All EN=0, all FLUSH=0.
  - MEM_TIMEOUT_ERR=1.
  - Left only by reset.
- STALL_CNT:
  - Increments on each cycle with RST_N=1 and PC_EN=0.
  - Saturates at all-ones; never wraps.
- Reset asserted mid-MEM_WAIT: immediate return to RUN, counters cleared; no residual stall after release.

Decomposition:
- pipeline_ctrl_pkg holds:
  - the state encoding (RUN/LOAD_STALL/MEM_WAIT/ERROR);
  - WB_SEL encodings (WB_SEL_ALU=2'b00, WB_SEL_MEM=2'b01, WB_SEL_PC4=2'b10, WB_SEL_IMM=2'b11);
  - a REG_X0 constant.
- One sub-module: hazard_detect, a purely combinational load_use comparator instantiated once.

Test Plan:
- EX: lw x5 (WB_SEL=01, RD=5, WE=1); ID: add rs1=5 used -> PC_EN=0, IF_ID_EN=0, ID_EX_FLUSH=1 for exactly 1 cycle; STATE 00->01->00; STALL_CNT=1.
- Same as above but EX_RD=0, or ID_RS1_USED=0 -> no stall; all EN=1 every cycle.
- load_use and EX_BRANCH_TAKEN in the same cycle -> IF_ID_FLUSH=1, ID_EX_FLUSH=1, PC_EN=1; STATE stays RUN.
- MEM_REQ=1, MEM_ACK low 3 cycles then high -> EN=0 and MEM_WB_FLUSH=1 for 3 cycles; STATE=10; advance on ACK cycle; STALL_CNT+=3.
- MEM_REQ=1, MEM_ACK never (MEM_TIMEOUT=15) -> STATE=11 and MEM_TIMEOUT_ERR=1 after the 15th wait cycle; ACK arriving exactly on cycle 15 -> RUN, no error.
- Assert RST_N=0 mid-MEM_WAIT, and separately preload STALL_CNT near 16'hFFFF -> STATE=00 and counters 0 immediately on reset; the counter holds at 16'hFFFF under continued stall.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - ctrl_state_t : sequencer states (encoding is visible on the STATE port)
//   - WB_SEL_*     : writeback-select encodings used by the EX stage
//   - REG_X0       : architectural zero register (never a hazard source)
//   - strobes_t    : bundle of pipeline enable/flush strobes plus presets
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'b00,
        ST_LOAD_STALL = 2'b01,
        ST_MEM_WAIT   = 2'b10,
        ST_ERROR      = 2'b11
    } ctrl_state_t;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;
    localparam logic [1:0] WB_SEL_IMM = 2'b11;

    localparam logic [4:0] REG_X0 = 5'd0;

    // Field order fixes the packed bit order: pc_en is the MSB.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic mem_wb_flush;
    } strobes_t;

    // Free-running pipeline.
    localparam strobes_t STB_ADVANCE = 7'b1101010;
    // Taken branch: everything advances, the two younger stages are squashed.
    localparam strobes_t STB_BRANCH  = 7'b1111110;
    // Load-use: hold PC and IF/ID, inject one bubble into ID/EX.
    localparam strobes_t STB_BUBBLE  = 7'b0001110;
    // Data memory busy: freeze everything upstream, bubble into MEM/WB.
    localparam strobes_t STB_MEMHOLD = 7'b0000001;
    // Dead pipeline (error or reset).
    localparam strobes_t STB_OFF     = 7'b0000000;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator.
//   Inputs : ID-stage source registers and their use flags, EX-stage
//            destination, write enable and writeback select.
//   Output : load_use, high when the EX instruction is a load whose
//            result the ID instruction needs next cycle.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] ex_rd,
    input  logic       ex_reg_write_en,
    input  logic [1:0] ex_wb_sel,
    output logic       load_use
);

    logic ex_is_load;
    logic rs1_match;
    logic rs2_match;

    // Writes to x0 are discarded, so they can never create a dependency.
    assign ex_is_load = (ex_wb_sel == WB_SEL_MEM) && ex_reg_write_en && (ex_rd != REG_X0);
    assign rs1_match  = id_rs1_used && (id_rs1 == ex_rd);
    assign rs2_match  = id_rs2_used && (id_rs2 == ex_rd);
    assign load_use   = ex_is_load && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//   Inputs : CLK, RST_N (async, active low), ID source regs/use flags,
//            EX rd/write-enable/wb-select, EX_BRANCH_TAKEN, MEM_REQ, MEM_ACK.
//   Outputs: PC_EN, per-register *_EN / *_FLUSH strobes, STATE,
//            MEM_TIMEOUT_ERR (sticky until reset), STALL_CNT (saturating
//            count of cycles with PC_EN low).
// Strobes are combinational from state and inputs; state and counters are
// registered. Priority outside MEM_WAIT is mem_hold > branch > load_use.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [4:0]             ID_RS1,
    input  logic [4:0]             ID_RS2,
    input  logic                   ID_RS1_USED,
    input  logic                   ID_RS2_USED,
    input  logic [4:0]             EX_RD,
    input  logic                   EX_REG_WRITE_EN,
    input  logic [1:0]             EX_WB_SEL,
    input  logic                   EX_BRANCH_TAKEN,
    input  logic                   MEM_REQ,
    input  logic                   MEM_ACK,
    output logic                   PC_EN,
    output logic                   IF_ID_EN,
    output logic                   IF_ID_FLUSH,
    output logic                   ID_EX_EN,
    output logic                   ID_EX_FLUSH,
    output logic                   EX_MEM_EN,
    output logic                   MEM_WB_FLUSH,
    output logic [1:0]             STATE,
    output logic                   MEM_TIMEOUT_ERR,
    output logic [STALL_CNT_W-1:0] STALL_CNT
);

    // MEM_TIMEOUT is limited to 1..255, so an 8-bit wait counter suffices.
    localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

    ctrl_state_t            state_reg, state_next;
    logic [7:0]             wait_cnt_reg, wait_cnt_next;
    logic [STALL_CNT_W-1:0] stall_cnt_reg;
    strobes_t               stb_next;
    strobes_t               stb_out;
    logic                   load_use;
    logic                   mem_hold;

    hazard_detect u_hazard_detect (
        .id_rs1          (ID_RS1),
        .id_rs2          (ID_RS2),
        .id_rs1_used     (ID_RS1_USED),
        .id_rs2_used     (ID_RS2_USED),
        .ex_rd           (EX_RD),
        .ex_reg_write_en (EX_REG_WRITE_EN),
        .ex_wb_sel       (EX_WB_SEL),
        .load_use        (load_use)
    );

    assign mem_hold = MEM_REQ && !MEM_ACK;

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        stb_next      = STB_ADVANCE;
        case (state_reg)
            ST_RUN, ST_LOAD_STALL: begin
                if (mem_hold) begin
                    stb_next      = STB_MEMHOLD;
                    state_next    = ST_MEM_WAIT;
                    wait_cnt_next = 8'd1;
                end else if (EX_BRANCH_TAKEN) begin
                    // The dependent instruction is squashed, so no bubble.
                    stb_next   = STB_BRANCH;
                    state_next = ST_RUN;
                end else if (load_use && (state_reg == ST_RUN)) begin
                    // Masked in LOAD_STALL so each hazard costs one bubble.
                    stb_next   = STB_BUBBLE;
                    state_next = ST_LOAD_STALL;
                end else begin
                    state_next = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (MEM_ACK) begin
                    // Acknowledge wins over a coincident timeout.
                    stb_next      = EX_BRANCH_TAKEN ? STB_BRANCH : STB_ADVANCE;
                    state_next    = ST_RUN;
                    wait_cnt_next = 8'd0;
                end else begin
                    stb_next = STB_MEMHOLD;
                    if (wait_cnt_reg == TIMEOUT_VAL) begin
                        state_next = ST_ERROR;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + 8'd1;
                    end
                end
            end
            ST_ERROR: begin
                stb_next = STB_OFF;
            end
            default: begin
                stb_next   = STB_OFF;
                state_next = ST_RUN;
            end
        endcase
    end

    // Strobes are forced off for as long as reset is held, not just at its edge.
    assign stb_out = RST_N ? stb_next : STB_OFF;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg     <= ST_RUN;
            wait_cnt_reg  <= 8'd0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (!stb_out.pc_en && (stall_cnt_reg != {STALL_CNT_W{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
        end
    end

    assign PC_EN           = stb_out.pc_en;
    assign IF_ID_EN        = stb_out.if_id_en;
    assign IF_ID_FLUSH     = stb_out.if_id_flush;
    assign ID_EX_EN        = stb_out.id_ex_en;
    assign ID_EX_FLUSH     = stb_out.id_ex_flush;
    assign EX_MEM_EN       = stb_out.ex_mem_en;
    assign MEM_WB_FLUSH    = stb_out.mem_wb_flush;
    assign STATE           = state_reg;
    assign MEM_TIMEOUT_ERR = (state_reg == ST_ERROR);
    assign STALL_CNT       = stall_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: randomized traffic plus
// directed scenarios, all compared every cycle against a behavioural model.
// A narrow stall counter is used so saturation is reached quickly.
module tb_pipeline_hazard_ctrl;

    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 12;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // Model modes.
    localparam int M_RUN    = 0;
    localparam int M_BUBBLE = 1;
    localparam int M_WAIT   = 2;
    localparam int M_DEAD   = 3;

    // Expected strobe vectors {PC_EN,IF_ID_EN,IF_ID_FLUSH,ID_EX_EN,ID_EX_FLUSH,EX_MEM_EN,MEM_WB_FLUSH}.
    localparam logic [6:0] E_GO     = 7'b1101010;
    localparam logic [6:0] E_SQUASH = 7'b1111110;
    localparam logic [6:0] E_STALL  = 7'b0001110;
    localparam logic [6:0] E_FROZEN = 7'b0000001;
    localparam logic [6:0] E_NONE   = 7'b0000000;

    logic             CLK;
    logic             RST_N;
    logic [4:0]       ID_RS1, ID_RS2, EX_RD;
    logic             ID_RS1_USED, ID_RS2_USED, EX_REG_WRITE_EN;
    logic [1:0]       EX_WB_SEL;
    logic             EX_BRANCH_TAKEN, MEM_REQ, MEM_ACK;
    logic             PC_EN, IF_ID_EN, IF_ID_FLUSH, ID_EX_EN, ID_EX_FLUSH, EX_MEM_EN, MEM_WB_FLUSH;
    logic [1:0]       STATE;
    logic             MEM_TIMEOUT_ERR;
    logic [CNT_W-1:0] STALL_CNT;

    int checks   = 0;
    int failures = 0;

    int         m_mode;
    int         m_waits;
    int         m_stalls;
    logic [6:0] e_stb;
    int         e_mode;
    int         e_waits;

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT (TIMEOUT),
        .STALL_CNT_W (CNT_W)
    ) dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .ID_RS1          (ID_RS1),
        .ID_RS2          (ID_RS2),
        .ID_RS1_USED     (ID_RS1_USED),
        .ID_RS2_USED     (ID_RS2_USED),
        .EX_RD           (EX_RD),
        .EX_REG_WRITE_EN (EX_REG_WRITE_EN),
        .EX_WB_SEL       (EX_WB_SEL),
        .EX_BRANCH_TAKEN (EX_BRANCH_TAKEN),
        .MEM_REQ         (MEM_REQ),
        .MEM_ACK         (MEM_ACK),
        .PC_EN           (PC_EN),
        .IF_ID_EN        (IF_ID_EN),
        .IF_ID_FLUSH     (IF_ID_FLUSH),
        .ID_EX_EN        (ID_EX_EN),
        .ID_EX_FLUSH     (ID_EX_FLUSH),
        .EX_MEM_EN       (EX_MEM_EN),
        .MEM_WB_FLUSH    (MEM_WB_FLUSH),
        .STATE           (STATE),
        .MEM_TIMEOUT_ERR (MEM_TIMEOUT_ERR),
        .STALL_CNT       (STALL_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] mode_code(input int mode);
        case (mode)
            M_BUBBLE: return 2'b01;
            M_WAIT:   return 2'b10;
            M_DEAD:   return 2'b11;
            default:  return 2'b00;
        endcase
    endfunction

    // Expected strobes and successor mode from the current mode and inputs.
    task automatic model_eval();
        bit needs_load_result;
        bit mem_busy;
        needs_load_result = (EX_WB_SEL == 2'b01) && EX_REG_WRITE_EN && (EX_RD != 5'd0) &&
                            ((ID_RS1_USED && ID_RS1 == EX_RD) || (ID_RS2_USED && ID_RS2 == EX_RD));
        mem_busy = MEM_REQ && !MEM_ACK;
        e_mode  = m_mode;
        e_waits = m_waits;
        if (!RST_N) begin
            e_stb  = E_NONE;
            e_mode = M_RUN;
        end else if (m_mode == M_DEAD) begin
            e_stb = E_NONE;
        end else if (m_mode == M_WAIT) begin
            if (MEM_ACK) begin
                e_stb  = EX_BRANCH_TAKEN ? E_SQUASH : E_GO;
                e_mode = M_RUN;
            end else if (m_waits >= TIMEOUT) begin
                e_stb  = E_FROZEN;
                e_mode = M_DEAD;
            end else begin
                e_stb   = E_FROZEN;
                e_waits = m_waits + 1;
            end
        end else if (mem_busy) begin
            e_stb   = E_FROZEN;
            e_mode  = M_WAIT;
            e_waits = 1;
        end else if (EX_BRANCH_TAKEN) begin
            e_stb  = E_SQUASH;
            e_mode = M_RUN;
        end else if (needs_load_result && m_mode == M_RUN) begin
            e_stb  = E_STALL;
            e_mode = M_BUBBLE;
        end else begin
            e_stb  = E_GO;
            e_mode = M_RUN;
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic step(input string tag);
        @(negedge CLK);
        model_eval();
        check_val({tag, ":strobes"}, 32'({PC_EN, IF_ID_EN, IF_ID_FLUSH, ID_EX_EN, ID_EX_FLUSH, EX_MEM_EN, MEM_WB_FLUSH}), 32'(e_stb));
        check_val({tag, ":state"}, 32'(STATE), 32'(mode_code(m_mode)));
        check_val({tag, ":err"}, 32'(MEM_TIMEOUT_ERR), 32'(m_mode == M_DEAD));
        check_val({tag, ":stall_cnt"}, 32'(STALL_CNT), 32'(m_stalls));
        @(posedge CLK);
        if (RST_N) begin
            if (!e_stb[6] && m_stalls < CNT_MAX) m_stalls++;
            m_mode  = e_mode;
            m_waits = e_waits;
        end else begin
            m_mode   = M_RUN;
            m_waits  = 0;
            m_stalls = 0;
        end
        #1;
    endtask

    task automatic set_idle();
        ID_RS1 = 5'd0; ID_RS2 = 5'd0; ID_RS1_USED = 1'b0; ID_RS2_USED = 1'b0;
        EX_RD = 5'd0; EX_REG_WRITE_EN = 1'b0; EX_WB_SEL = 2'b00;
        EX_BRANCH_TAKEN = 1'b0; MEM_REQ = 1'b0; MEM_ACK = 1'b0;
    endtask

    task automatic set_lw_dep(input logic [4:0] rd, input logic rs1_used);
        EX_RD = rd; EX_REG_WRITE_EN = 1'b1; EX_WB_SEL = 2'b01;
        ID_RS1 = 5'd5; ID_RS1_USED = rs1_used; ID_RS2 = 5'd9; ID_RS2_USED = 1'b1;
    endtask

    // Reset asserted between clock edges; its effect must be immediate.
    task automatic do_reset(input string tag);
        @(negedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        check_val({tag, ":rst_strobes"}, 32'({PC_EN, IF_ID_EN, IF_ID_FLUSH, ID_EX_EN, ID_EX_FLUSH, EX_MEM_EN, MEM_WB_FLUSH}), 32'(E_NONE));
        check_val({tag, ":rst_state"}, 32'(STATE), 32'd0);
        check_val({tag, ":rst_cnt"}, 32'(STALL_CNT), 32'd0);
        check_val({tag, ":rst_err"}, 32'(MEM_TIMEOUT_ERR), 32'd0);
        m_mode = M_RUN; m_waits = 0; m_stalls = 0;
        step({tag, ":held"});
        @(negedge CLK);
        #2;
        RST_N = 1'b1;
    endtask

    initial begin
        set_idle();
        RST_N    = 1'b0;
        m_mode   = M_RUN;
        m_waits  = 0;
        m_stalls = 0;
        step("init_rst");
        step("init_rst");
        @(negedge CLK);
        #2;
        RST_N = 1'b1;
        step("post_rst");
        $display("txn reset_release state=%0d stall_cnt=%0d", STATE, STALL_CNT);

        // Load-use on rs1: one bubble, then masked while the bubble drains.
        set_lw_dep(5'd5, 1'b1);
        step("lu_stall");
        step("lu_masked");
        set_idle();
        step("lu_after");
        check_val("lu_stall_cnt", 32'(STALL_CNT), 32'd1);
        $display("txn load_use stall_cnt=%0d", STALL_CNT);

        // No hazard for x0 destination or unused source.
        set_lw_dep(5'd0, 1'b1);
        step("lu_x0");
        set_lw_dep(5'd5, 1'b0);
        step("lu_unused");
        set_idle();
        $display("txn no_hazard pc_en=%0d", PC_EN);

        // Branch squashes a simultaneous load-use.
        set_lw_dep(5'd5, 1'b1);
        EX_BRANCH_TAKEN = 1'b1;
        step("br_lu");
        set_idle();
        step("br_after");
        $display("txn branch_vs_load_use state=%0d", STATE);

        // Memory wait of three stalled cycles then acknowledge.
        MEM_REQ = 1'b1;
        for (int i = 0; i < 3; i++) step("mem3_wait");
        MEM_ACK = 1'b1;
        step("mem3_ack");
        set_idle();
        step("mem3_after");
        check_val("mem3_stall_cnt", 32'(STALL_CNT), 32'd4);
        $display("txn mem_wait3 stall_cnt=%0d", STALL_CNT);

        // Acknowledge exactly on the timeout cycle wins.
        MEM_REQ = 1'b1;
        for (int i = 0; i < TIMEOUT; i++) step("to_edge_wait");
        MEM_ACK = 1'b1;
        step("to_edge_ack");
        set_idle();
        step("to_edge_after");
        check_val("to_edge_state", 32'(STATE), 32'd0);
        $display("txn timeout_edge_ack state=%0d err=%0d", STATE, MEM_TIMEOUT_ERR);

        // No acknowledge: error after the last permitted wait cycle.
        MEM_REQ = 1'b1;
        for (int i = 0; i <= TIMEOUT; i++) step("to_wait");
        step("to_error");
        check_val("to_state", 32'(STATE), 32'd3);
        check_val("to_err", 32'(MEM_TIMEOUT_ERR), 32'd1);
        $display("txn timeout state=%0d err=%0d", STATE, MEM_TIMEOUT_ERR);

        // Error keeps PC_EN low: counter must saturate and hold.
        set_idle();
        MEM_ACK = 1'b1;
        for (int i = 0; i < CNT_MAX + 20; i++) step("sat");
        check_val("sat_hold", 32'(STALL_CNT), 32'(CNT_MAX));
        $display("txn saturation stall_cnt=%0h", STALL_CNT);

        // Reset in the middle of a memory wait.
        do_reset("rst_err");
        set_idle();
        step("rst_err_after");
        MEM_REQ = 1'b1;
        for (int i = 0; i < 4; i++) step("midwait");
        do_reset("rst_mid");
        set_idle();
        for (int i = 0; i < 3; i++) step("rst_mid_after");
        $display("txn reset_mid_wait state=%0d stall_cnt=%0d", STATE, STALL_CNT);

        // Randomized traffic with small register ranges so hazards are frequent.
        for (int i = 0; i < 3000; i++) begin
            ID_RS1          = 5'($urandom_range(0, 3));
            ID_RS2          = 5'($urandom_range(0, 3));
            ID_RS1_USED     = 1'($urandom_range(0, 1));
            ID_RS2_USED     = 1'($urandom_range(0, 1));
            EX_RD           = 5'($urandom_range(0, 3));
            EX_REG_WRITE_EN = ($urandom_range(0, 3) != 0);
            EX_WB_SEL       = 2'($urandom_range(0, 3));
            EX_BRANCH_TAKEN = ($urandom_range(0, 5) == 0);
            MEM_REQ         = ($urandom_range(0, 3) == 0);
            MEM_ACK         = ($urandom_range(0, 9) < 3);
            step("rand");
            if (m_mode == M_DEAD && $urandom_range(0, 3) == 0) do_reset("rand_rst");
        end
        $display("txn random_traffic checks=%0d", checks);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
